lcd_capture: RTL

LCD_CAPTURE -- requirements
Module: lcd_capture

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/sync_edge.sv | 29 ++
 rtl/lcd_capture.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and address helper for the LCD capture block.
package lcd_pkg;

   localparam logic [7:0]  H_PIXELS       = 8'd160;
   localparam logic [7:0]  V_LINES        = 8'd144;
   localparam logic [12:0] BYTES_PER_LINE = 13'd40;
   localparam logic [12:0] FB_BYTES       = 13'd5760;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_LINE,
      ACTIVE,
      LINE_END
   } lcd_state_t;

   // Byte address of the packed byte holding pixel column 'col' of line 'line'.
   // The sum is kept at 13 bits so it wraps around the 8 KiB framebuffer.
   function automatic logic [12:0] byte_addr(input logic [12:0] base,
                                             input logic [7:0]  line,
                                             input logic [7:0]  col);
      logic [12:0] line_ext;
      line_ext = {5'd0, line};
      return base + (line_ext * BYTES_PER_LINE) + {7'd0, col[7:2]};
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// The pulse appears two clocks after the first edge that samples the input high.
module sync_edge (
   input  logic clock,
   input  logic reset_n,
   input  logic sig,
   output logic rise
);

   logic meta;
   logic sync;
   logic sync_q;

   // Synchronize the asynchronous input and flag a low-to-high transition for one cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_q <= 1'b0;
         rise   <= 1'b0;
      end else begin
         meta   <= sig;
         sync   <= meta;
         sync_q <= sync;
         rise   <= sync & ~sync_q;
      end
   end

endmodule

// File: rtl/lcd_capture.sv
// Captures the 2-bit gameboy LCD pixel stream into a packed framebuffer,
// four pixels per byte, 40 bytes per line, 144 lines per frame.
module lcd_capture
   import lcd_pkg::*;
#(
   parameter logic [12:0] FB_BASE = 13'h0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        capture_en,
   input  logic [1:0]  pixel_data,
   input  logic        pixel_clock,
   input  logic        pixel_latch,
   input  logic        hsync,
   input  logic        vsync,
   output logic [12:0] fb_addr,
   output logic [7:0]  fb_wr_data,
   output logic        fb_wr_cs,
   output logic        frame_done,
   output logic [7:0]  frame_count,
   output logic [2:0]  err_flags,
   input  logic        err_clr
);

   logic       pclk_rise;
   logic       latch_rise;
   logic       hsync_rise;
   logic       vsync_rise;
   logic [1:0] data_d1;
   logic [1:0] data_d2;
   logic [1:0] data_d3;

   lcd_state_t  state;
   lcd_state_t  state_next;
   logic [7:0]  line_cnt;
   logic [7:0]  line_next;
   logic [7:0]  col_cnt;
   logic [7:0]  col_next;
   logic [7:0]  shreg;
   logic [7:0]  shreg_next;
   logic [12:0] addr_next;
   logic [7:0]  data_next;
   logic        cs_next;
   logic        done_next;
   logic [7:0]  count_next;
   logic [2:0]  err_new;
   logic [2:0]  err_next;
   logic [7:0]  col_work;
   logic [7:0]  shreg_work;
   logic [7:0]  padded;

   sync_edge u_sync_pclk  (.clock(clock), .reset_n(reset_n), .sig(pixel_clock), .rise(pclk_rise));
   sync_edge u_sync_latch (.clock(clock), .reset_n(reset_n), .sig(pixel_latch), .rise(latch_rise));
   sync_edge u_sync_hsync (.clock(clock), .reset_n(reset_n), .sig(hsync),       .rise(hsync_rise));
   sync_edge u_sync_vsync (.clock(clock), .reset_n(reset_n), .sig(vsync),       .rise(vsync_rise));

   // Delay pixel data by three stages so it lines up with the pixel_clock edge pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_d1 <= 2'b00;
         data_d2 <= 2'b00;
         data_d3 <= 2'b00;
      end else begin
         data_d1 <= pixel_data;
         data_d2 <= data_d1;
         data_d3 <= data_d2;
      end
   end

   // Capture state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath decode; vsync outranks pixel, pixel outranks latch, latch outranks hsync.
   always_comb begin
      state_next = state;
      line_next  = line_cnt;
      col_next   = col_cnt;
      shreg_next = shreg;
      addr_next  = fb_addr;
      data_next  = fb_wr_data;
      cs_next    = 1'b0;
      done_next  = 1'b0;
      count_next = frame_count;
      err_new    = 3'b000;
      col_work   = col_cnt;
      shreg_work = shreg;
      padded     = 8'h00;

      if (vsync_rise) begin
         if (state != IDLE) begin
            err_new[2] = 1'b1;
         end
         line_next  = 8'd0;
         col_next   = 8'd0;
         shreg_next = 8'h00;
         state_next = capture_en ? WAIT_LINE : IDLE;
      end else begin
         case (state)
            IDLE: begin
               state_next = IDLE;
            end

            WAIT_LINE: begin
               if (hsync_rise) begin
                  state_next = ACTIVE;
                  col_next   = 8'd0;
                  shreg_next = 8'h00;
               end
            end

            ACTIVE: begin
               if (pclk_rise) begin
                  if (col_cnt < H_PIXELS) begin
                     shreg_work = {shreg[5:0], data_d3};
                     if (col_cnt[1:0] == 2'd3) begin
                        cs_next    = 1'b1;
                        addr_next  = byte_addr(FB_BASE, line_cnt, col_cnt);
                        data_next  = shreg_work;
                        shreg_work = 8'h00;
                     end
                     col_work = col_cnt + 8'd1;
                  end else begin
                     err_new[0] = 1'b1;
                  end
               end
               if (latch_rise) begin
                  if (col_work < H_PIXELS) begin
                     err_new[1] = 1'b1;
                     if (col_work[1:0] != 2'd0) begin
                        case (col_work[1:0])
                           2'd1:    padded = shreg_work << 6;
                           2'd2:    padded = shreg_work << 4;
                           default: padded = shreg_work << 2;
                        endcase
                        cs_next   = 1'b1;
                        addr_next = byte_addr(FB_BASE, line_cnt, col_work);
                        data_next = padded;
                     end
                  end
                  shreg_work = 8'h00;
                  line_next  = line_cnt + 8'd1;
                  state_next = LINE_END;
               end
               col_next   = col_work;
               shreg_next = shreg_work;
            end

            LINE_END: begin
               if (line_cnt == V_LINES) begin
                  done_next  = 1'b1;
                  count_next = frame_count + 8'd1;
                  state_next = IDLE;
               end else if (hsync_rise) begin
                  state_next = ACTIVE;
                  col_next   = 8'd0;
                  shreg_next = 8'h00;
               end else begin
                  state_next = WAIT_LINE;
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end

      err_next = (err_clr ? 3'b000 : err_flags) | err_new;
   end

   // Datapath registers, write strobe, frame bookkeeping and sticky error flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         line_cnt    <= 8'd0;
         col_cnt     <= 8'd0;
         shreg       <= 8'h00;
         fb_addr     <= 13'd0;
         fb_wr_data  <= 8'h00;
         fb_wr_cs    <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= 8'd0;
         err_flags   <= 3'b000;
      end else begin
         line_cnt    <= line_next;
         col_cnt     <= col_next;
         shreg       <= shreg_next;
         fb_addr     <= addr_next;
         fb_wr_data  <= data_next;
         fb_wr_cs    <= cs_next;
         frame_done  <= done_next;
         frame_count <= count_next;
         err_flags   <= err_next;
      end
   end

endmodule
